// File: rtl/evt_debounce_edge.sv
// evt_debounce_edge: conditions an asynchronous raw input into a clean,
// single-cycle event pulse. The pipeline runs raw_in through a synchroniser,
// then a debounce FSM, then an edge selector.
// Optional build macro EVT_DEBOUNCE_CNT_EN: when it is defined, a saturating
// counter of emitted events drives evt_count. When it is undefined, evt_count
// is tied to zero.
module evt_debounce_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 8,
  parameter int EDGE_MODE   = 0,
  parameter int EVT_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 raw_in,
  output logic                 evt,
  output logic                 level,
  output logic [EVT_CNT_W-1:0] evt_count
);

  // The debounce counter must be able to hold DB_CYCLES.
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Edge modes outside 0..2 fall back to rising-only.
  localparam int   EM      = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;
  localparam logic RISE_EN = (EM != 1) ? 1'b1 : 1'b0;
  localparam logic FALL_EN = (EM != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   evt_r;
  logic                   rise_acc_s;
  logic                   fall_acc_s;
  logic                   fire_s;

  // Synchroniser chain: this is the only logic that samples raw_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // Detect the cycle on which a level change is accepted.
  always_comb begin
    rise_acc_s = 1'b0;
    fall_acc_s = 1'b0;
    case (state_r)
      S_LOW: begin
        if (s_s && (DB_CYCLES == 1)) rise_acc_s = 1'b1;
        else                         rise_acc_s = 1'b0;
      end
      S_WAIT_HI: begin
        if (s_s && (cnt_r == DB_LAST)) rise_acc_s = 1'b1;
        else                           rise_acc_s = 1'b0;
      end
      S_HIGH: begin
        if (!s_s && (DB_CYCLES == 1)) fall_acc_s = 1'b1;
        else                          fall_acc_s = 1'b0;
      end
      S_WAIT_LO: begin
        if (!s_s && (cnt_r == DB_LAST)) fall_acc_s = 1'b1;
        else                            fall_acc_s = 1'b0;
      end
      default: begin
        rise_acc_s = 1'b0;
        fall_acc_s = 1'b0;
      end
    endcase
  end

  // An event fires only for a selected edge while enabled. Edges accepted
  // while en is low are dropped.
  assign fire_s = en & ((rise_acc_s & RISE_EN) | (fall_acc_s & FALL_EN));

  // Debounce FSM with registered level and event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_LOW;
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
      evt_r   <= 1'b0;
    end else begin
      evt_r <= fire_s;
      case (state_r)
        S_LOW: begin
          if (rise_acc_s) begin
            state_r <= S_HIGH;
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (s_s) begin
            state_r <= S_WAIT_HI;
            cnt_r   <= CNT_W'(1);
          end else begin
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        S_WAIT_HI: begin
          if (!s_s) begin
            state_r <= S_LOW;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (rise_acc_s) begin
            state_r <= S_HIGH;
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (fall_acc_s) begin
            state_r <= S_LOW;
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (!s_s) begin
            state_r <= S_WAIT_LO;
            cnt_r   <= CNT_W'(1);
          end else begin
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        S_WAIT_LO: begin
          if (s_s) begin
            state_r <= S_HIGH;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (fall_acc_s) begin
            state_r <= S_LOW;
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= S_LOW;
          cnt_r   <= {CNT_W{1'b0}};
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign evt   = evt_r;
  assign level = level_r;

`ifdef EVT_DEBOUNCE_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt_r;

  // Saturating event counter. It updates on the same edge that raises evt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt_r <= {EVT_CNT_W{1'b0}};
    end else if (fire_s && (evt_cnt_r != {EVT_CNT_W{1'b1}})) begin
      evt_cnt_r <= evt_cnt_r + EVT_CNT_W'(1);
    end else begin
      evt_cnt_r <= evt_cnt_r;
    end
  end

  assign evt_count = evt_cnt_r;
`else
  assign evt_count = {EVT_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_evt_debounce_edge.sv
// Scoreboard bench for evt_debounce_edge. Four instances share one stimulus
// stream:
//   u0: rising edges only, 8-bit counter
//   u1: falling edges only, 2-bit counter
//   u2: both edges, 8-bit counter
//   u3: out-of-range EDGE_MODE, which must behave like rising edges
// The stimulus pushes each expected event (cycle and count) into a queue for
// its instance. A separate monitor pops an entry whenever evt is seen.
module tb_evt_debounce_edge;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic en;
  logic raw_in;
  logic evt_v [4];
  logic lvl_v [4];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;
  logic [7:0] cnt3;
  int   cnt_v [4];
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb [4][$];

  evt_debounce_edge #(.EDGE_MODE(0), .EVT_CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .evt(evt_v[0]), .level(lvl_v[0]), .evt_count(cnt0));
  evt_debounce_edge #(.EDGE_MODE(1), .EVT_CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .evt(evt_v[1]), .level(lvl_v[1]), .evt_count(cnt1));
  evt_debounce_edge #(.EDGE_MODE(2), .EVT_CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .evt(evt_v[2]), .level(lvl_v[2]), .evt_count(cnt2));
  evt_debounce_edge #(.EDGE_MODE(5), .EVT_CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
    .evt(evt_v[3]), .level(lvl_v[3]), .evt_count(cnt3));

  assign cnt_v[0] = int'(cnt0);
  assign cnt_v[1] = int'(cnt1);
  assign cnt_v[2] = int'(cnt2);
  assign cnt_v[3] = int'(cnt3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count posedges: cyc equals the number of edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The count that is expected depends on whether the counter is built in.
  function automatic int ec(input int c);
`ifdef EVT_DEBOUNCE_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int id, input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = ec(n);
    sb[id].push_back(e);
  endtask

  // Advance to 1 time unit after edge n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_evt%0d", i), int'(evt_v[i]), 0);
      chk($sformatf("rst_lvl%0d", i), int'(lvl_v[i]), 0);
      chk($sformatf("rst_cnt%0d", i), cnt_v[i], 0);
    end
  endtask

  task automatic chk_levels(input string name, input int req);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_u%0d", name, i), int'(lvl_v[i]), req);
  endtask

  // Monitor: pops expectations on evt, and flags missed or unexpected events.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        while (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
          chk($sformatf("missed_evt_u%0d_at_%0d", i, sb[i][0].cyc), 0, 1);
          void'(sb[i].pop_front());
        end
        if (evt_v[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("unexpected_evt_u%0d", i), 1, 0);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk($sformatf("evt_cycle_u%0d", i), cyc, e.cyc);
            chk($sformatf("evt_count_u%0d", i), cnt_v[i], e.cnt);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b1;
    raw_in = 1'b0;

    // Values held during reset.
    wait_cyc(2);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Clean rise: first sampled at edge 10, accepted at edge 19.
    wait_cyc(9);
    raw_in = 1'b1;
    push(0, 19, 1); push(3, 19, 1); push(2, 19, 1);
    wait_cyc(18); chk_levels("lvl_pre_rise", 0);
    wait_cyc(19); chk_levels("lvl_rise", 1);

    // A 20-cycle-wide pulse gives a fall 20 cycles after the rise.
    wait_cyc(29);
    raw_in = 1'b0;
    push(1, 39, 1); push(2, 39, 2);

    // Glitches: 5 samples, then DB_CYCLES-1 = 7 samples. Neither is accepted.
    wait_cyc(50); raw_in = 1'b1;
    wait_cyc(55); raw_in = 1'b0;
    wait_cyc(70); raw_in = 1'b1;
    wait_cyc(77); raw_in = 1'b0;
    wait_cyc(90); chk_levels("lvl_after_glitch", 0);

    // A rise accepted at edge 100 while en=0: level tracks, and the event is dropped.
    en = 1'b0;
    raw_in = 1'b1;
    wait_cyc(101); chk_levels("lvl_en_off", 1);
    wait_cyc(105); en = 1'b1;
    wait_cyc(110);
    raw_in = 1'b0;
    push(1, 120, 2); push(2, 120, 3);

    // A pulse of exactly DB_CYCLES samples is accepted. Its fall follows 8 edges later.
    wait_cyc(130);
    raw_in = 1'b1;
    push(0, 140, 2); push(3, 140, 2); push(2, 140, 4);
    wait_cyc(138);
    raw_in = 1'b0;
    push(1, 148, 3); push(2, 148, 5);

    // Reset mid-debounce while raw_in stays high.
    wait_cyc(170);
    raw_in = 1'b1;
    wait_cyc(176);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    wait_cyc(178);
    rst = 1'b0;
    push(0, 188, 1); push(3, 188, 1); push(2, 188, 1);
    wait_cyc(187); chk_levels("lvl_pre_rst_rise", 0);
    wait_cyc(188); chk_levels("lvl_rst_rise", 1);

    // Repeated pulses exercise saturation of u1's 2-bit counter.
    wait_cyc(200);
    raw_in = 1'b0;
    push(1, 210, 1); push(2, 210, 2);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(220 + 40 * i);
      raw_in = 1'b1;
      push(0, 230 + 40 * i, 2 + i);
      push(3, 230 + 40 * i, 2 + i);
      push(2, 230 + 40 * i, 3 + 2 * i);
      wait_cyc(240 + 40 * i);
      raw_in = 1'b0;
      push(1, 250 + 40 * i, (2 + i > 3) ? 3 : 2 + i);
      push(2, 250 + 40 * i, 4 + 2 * i);
    end

    // Final state.
    wait_cyc(400);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_empty_u%0d", i), sb[i].size(), 0);
      chk($sformatf("final_lvl_u%0d", i), int'(lvl_v[i]), 0);
    end
    chk("final_cnt_u0", cnt_v[0], ec(5));
    chk("final_cnt_u1", cnt_v[1], ec(3));
    chk("final_cnt_u2", cnt_v[2], ec(10));
    chk("final_cnt_u3", cnt_v[3], ec(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
